// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the TX FIFO frame drain: state encoding, flag positions
// inside FIFO words and skid entries, and counter widths.
package fifo_drain_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DROP   = 2'd2
   } drain_state_e;

   // Flag bit offsets above the payload in a FIFO word
   localparam int unsigned FIFO_EOP_OFS = 0;
   localparam int unsigned FIFO_SOP_OFS = 1;

   // Flag bit offsets above the payload in a skid entry
   localparam int unsigned SKID_ERR_OFS = 0;
   localparam int unsigned SKID_EOP_OFS = 1;
   localparam int unsigned SKID_SOP_OFS = 2;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WCNT_W = 8;

endpackage

// File: rtl/drain_skid2.sv
// Two-entry valid/ready skid buffer with flow-through when empty, so a word
// returned by the FIFO is presented on the output in the same cycle.
module drain_skid2 #(
   parameter int unsigned W = 67
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_occ,
   output logic         o_pop
);

   logic [W-1:0] r_mem [2];
   logic [1:0]   r_cnt;
   logic [W-1:0] w_mem0_d;
   logic [W-1:0] w_mem1_d;
   logic [1:0]   w_cnt_d;
   logic         w_has;

   assign w_has   = (r_cnt != 2'd0);
   assign o_valid = w_has | i_valid;
   assign o_data  = w_has ? r_mem[0] : (i_valid ? i_data : '0);
   assign o_pop   = o_valid & i_ready;
   assign o_occ   = r_cnt;

   always_comb begin
      w_mem0_d = r_mem[0];
      w_mem1_d = r_mem[1];
      w_cnt_d  = r_cnt + {1'b0, i_valid} - {1'b0, o_pop};
      if (o_pop) begin
         w_mem0_d = r_mem[1];
      end
      // New entry lands at the tail; flow-through (w_cnt_d == 0) stores nothing
      if (i_valid && (w_cnt_d == 2'd1)) begin
         w_mem0_d = i_data;
      end
      if (i_valid && (w_cnt_d == 2'd2)) begin
         w_mem1_d = i_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt    <= 2'd0;
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else begin
         r_cnt    <= w_cnt_d;
         r_mem[0] <= w_mem0_d;
         r_mem[1] <= w_mem1_d;
      end
   end

endmodule

// File: rtl/fifo_frame_drain.sv
// Drains the MAC TX FIFO into a valid/ready frame stream, tagging sop/eop and
// truncating malformed or oversize frames with an error-flagged eop.
module fifo_frame_drain
   import fifo_drain_pkg::*;
#(
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned PTR          = 4,
   parameter int unsigned START_THRESH = 4,
   parameter int unsigned STALL_MAX    = 15,
   parameter int unsigned MAX_WORDS    = 190
) (
   input  logic                clk,
   input  logic                reset,
   output logic                fifo_rden,
   input  logic [DATA_W+1:0]   fifo_dataout,
   input  logic                fifo_rdempty,
   input  logic [PTR:0]        fifo_usedw,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_sop,
   output logic                out_eop,
   output logic                out_err,
   output logic [CNT_W-1:0]    frame_cnt,
   output logic [CNT_W-1:0]    drop_cnt
);

   localparam int unsigned SKID_W  = DATA_W + 3;
   localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
   localparam logic [PTR:0]        THRESH    = (PTR + 1)'(START_THRESH);
   localparam logic [STALL_W-1:0]  STALL_LIM = STALL_W'(STALL_MAX);
   localparam logic [WCNT_W-1:0]   WORD_LAST = WCNT_W'(MAX_WORDS - 1);

   drain_state_e        r_state;
   drain_state_e        w_state_d;
   logic                r_inflight;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [WCNT_W-1:0]   w_wcnt_d;
   logic [STALL_W-1:0]  r_stall;
   logic [STALL_W-1:0]  w_stall_d;
   logic [CNT_W-1:0]    r_frame_cnt;
   logic [CNT_W-1:0]    r_drop_cnt;
   logic                w_frame_inc;
   logic                w_drop_inc;
   logic                w_push;
   logic                w_push_sop;
   logic                w_push_eop;
   logic                w_push_err;
   logic                w_in_sop;
   logic                w_in_eop;
   logic                w_idle_go;
   logic [1:0]          w_occ;
   logic                w_pop;
   logic [2:0]          w_credit;
   logic [SKID_W-1:0]   w_skid_in;
   logic [SKID_W-1:0]   w_skid_out;

   assign w_in_sop  = fifo_dataout[DATA_W + FIFO_SOP_OFS];
   assign w_in_eop  = fifo_dataout[DATA_W + FIFO_EOP_OFS];
   // A word already returned while idle commits us to start a frame
   assign w_idle_go = (fifo_usedw >= THRESH) || (r_stall == STALL_LIM) || r_inflight;
   // Entries left after this cycle's pop, plus the read already in flight
   assign w_credit  = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
   assign fifo_rden = !reset && !fifo_rdempty && ((r_state != IDLE) || w_idle_go)
                      && (w_credit < 3'd2);

   always_comb begin
      w_state_d   = r_state;
      w_wcnt_d    = r_wcnt;
      w_push      = 1'b0;
      w_push_sop  = 1'b0;
      w_push_eop  = 1'b0;
      w_push_err  = 1'b0;
      w_frame_inc = 1'b0;
      w_drop_inc  = 1'b0;
      if ((r_state == IDLE) && w_idle_go) begin
         w_state_d = STREAM;
      end
      if (r_inflight) begin
         if (r_state == DROP) begin
            if (w_in_eop) begin
               w_state_d = IDLE;
            end
         end else begin
            w_wcnt_d = r_wcnt + WCNT_W'(1);
            if ((r_wcnt == '0) && !w_in_sop) begin
               w_drop_inc = 1'b1;
               w_state_d  = w_in_eop ? IDLE : DROP;
            end else if (r_wcnt == '0) begin
               w_push      = 1'b1;
               w_push_sop  = 1'b1;
               w_push_eop  = w_in_eop;
               w_frame_inc = w_in_eop;
               w_state_d   = w_in_eop ? IDLE : STREAM;
            end else if (w_in_sop || (!w_in_eop && (r_wcnt == WORD_LAST))) begin
               w_push     = 1'b1;
               w_push_eop = 1'b1;
               w_push_err = 1'b1;
               w_drop_inc = 1'b1;
               w_state_d  = w_in_eop ? IDLE : DROP;
            end else begin
               w_push      = 1'b1;
               w_push_eop  = w_in_eop;
               w_frame_inc = w_in_eop;
               if (w_in_eop) begin
                  w_state_d = IDLE;
               end
            end
         end
      end
      if (w_state_d != STREAM) begin
         w_wcnt_d = '0;
      end
   end

   always_comb begin
      w_stall_d = '0;
      if ((r_state == IDLE) && (w_state_d == IDLE)) begin
         w_stall_d = r_stall;
         if (!fifo_rdempty && (r_stall != STALL_LIM)) begin
            w_stall_d = r_stall + STALL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_inflight  <= 1'b0;
         r_wcnt      <= '0;
         r_stall     <= '0;
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_state    <= w_state_d;
         r_inflight <= fifo_rden;
         r_wcnt     <= w_wcnt_d;
         r_stall    <= w_stall_d;
         if (w_frame_inc) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
         if (w_drop_inc) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
      end
   end

   assign w_skid_in = {w_push_sop, w_push_eop, w_push_err, fifo_dataout[DATA_W-1:0]};

   drain_skid2 #(
      .W (SKID_W)
   ) u_skid (
      .i_clk   (clk),
      .i_reset (reset),
      .i_valid (w_push),
      .i_data  (w_skid_in),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (w_skid_out),
      .o_occ   (w_occ),
      .o_pop   (w_pop)
   );

   assign out_data  = w_skid_out[DATA_W-1:0];
   assign out_sop   = w_skid_out[DATA_W + SKID_SOP_OFS];
   assign out_eop   = w_skid_out[DATA_W + SKID_EOP_OFS];
   assign out_err   = w_skid_out[DATA_W + SKID_ERR_OFS];
   assign frame_cnt = r_frame_cnt;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fifo_frame_drain.sv
// Directed bench for fifo_frame_drain: a behavioural FIFO feeds the DUT and a
// word-level frame model fills a scoreboard that is checked at the output.
module tb_fifo_frame_drain;

   logic        clk = 1'b0;
   logic        reset;
   logic        fifo_rden;
   logic [65:0] fifo_dataout;
   logic        fifo_rdempty;
   logic [4:0]  fifo_usedw;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_sop;
   logic        out_eop;
   logic        out_err;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   fifo_frame_drain dut (
      .clk          (clk),
      .reset        (reset),
      .fifo_rden    (fifo_rden),
      .fifo_dataout (fifo_dataout),
      .fifo_rdempty (fifo_rdempty),
      .fifo_usedw   (fifo_usedw),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_sop      (out_sop),
      .out_eop      (out_eop),
      .out_err      (out_err),
      .frame_cnt    (frame_cnt),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   logic [65:0] fifo_q [$];
   logic [65:0] wr_q [$];
   logic [66:0] exp_q [$];

   int n_vec = 0;
   int n_err = 0;
   bit m_in = 1'b0;
   bit m_drop = 1'b0;
   int m_cnt = 0;
   int exp_frame = 0;
   int exp_drop = 0;

   int cyc = 0;
   int first_rden, first_use4, first_ne, v_first, v_last, v_cycles;
   int n_rd, n_acc, max_out;
   bit toggle_rdy = 1'b0;
   bit prev_stall = 1'b0;
   logic [66:0] prev_word;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic track_clear();
      first_rden = -1; first_use4 = -1; first_ne = -1;
      v_first = -1; v_last = -1; v_cycles = 0;
      n_rd = 0; n_acc = 0; max_out = 0;
   endtask

   // Queue a word for the FIFO and run the frame rules to predict the output
   task automatic put_word(input logic sop, input logic eop, input logic [63:0] pl);
      wr_q.push_back({sop, eop, pl});
      if (m_drop) begin
         if (eop) m_drop = 1'b0;
      end else if (!m_in) begin
         if (!sop) begin
            exp_drop++;
            m_drop = !eop;
         end else begin
            exp_q.push_back({1'b1, eop, 1'b0, pl});
            if (eop) exp_frame++;
            else begin
               m_in = 1'b1;
               m_cnt = 1;
            end
         end
      end else begin
         m_cnt++;
         if (sop) begin
            exp_q.push_back({1'b0, 1'b1, 1'b1, pl});
            exp_drop++;
            m_in = 1'b0;
            m_drop = !eop;
         end else if (eop) begin
            exp_q.push_back({1'b0, 1'b1, 1'b0, pl});
            exp_frame++;
            m_in = 1'b0;
         end else if (m_cnt == 190) begin
            exp_q.push_back({1'b0, 1'b1, 1'b1, pl});
            exp_drop++;
            m_in = 1'b0;
            m_drop = 1'b1;
         end else begin
            exp_q.push_back({1'b0, 1'b0, 1'b0, pl});
         end
      end
   endtask

   task automatic tick();
      logic        rd;
      logic [66:0] got;
      logic [66:0] want;
      @(negedge clk);
      cyc++;
      rd  = fifo_rden;
      got = {out_sop, out_eop, out_err, out_data};
      if (rd) chk("rden_while_empty", fifo_rdempty, 1'b0);
      if (prev_stall) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_word", got, prev_word);
      end
      if (rd && first_rden < 0) first_rden = cyc;
      if (fifo_usedw >= 5'd4 && first_use4 < 0) first_use4 = cyc;
      if (!fifo_rdempty && first_ne < 0) first_ne = cyc;
      if (out_valid) begin
         if (v_first < 0) v_first = cyc;
         v_last = cyc;
         v_cycles++;
      end
      if (out_valid && out_ready) begin
         n_acc++;
         chk("sb_has_entry", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("out_word", got, want);
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = got;
      if (rd) n_rd++;
      if (n_rd - n_acc > max_out) max_out = n_rd - n_acc;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() != 0) fifo_dataout = fifo_q.pop_front();
      if (wr_q.size() != 0 && fifo_q.size() < 16) fifo_q.push_back(wr_q.pop_front());
      fifo_usedw   = 5'(fifo_q.size());
      fifo_rdempty = (fifo_q.size() == 0);
      if (toggle_rdy) out_ready = !out_ready;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || wr_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_budget", n < budget, 1'b1);
      repeat (4) tick();
   endtask

   task automatic put_frame4();
      for (int i = 0; i < 4; i++) put_word(i == 0, i == 3, {$urandom, $urandom});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pl2;
      int n;
      reset        = 1'b1;
      out_ready    = 1'b1;
      fifo_rdempty = 1'b1;
      fifo_usedw   = '0;
      fifo_dataout = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rden", fifo_rden, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 64'h0);
      chk("rst_flags", {out_sop, out_eop, out_err}, 3'b000);
      chk("rst_frame_cnt", frame_cnt, 16'h0);
      chk("rst_drop_cnt", drop_cnt, 16'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) tick();

      // 4-word frame; reading starts as soon as usedw reaches 4
      track_clear();
      put_frame4();
      drain(100);
      chk("t1_rden_start", first_rden, first_use4);
      chk("t1_valid_run", v_last - v_first + 1, 4);
      chk("t1_valid_cycles", v_cycles, 4);
      chk("t1_frame_cnt", frame_cnt, 16'(exp_frame));

      // Single-word frame below threshold escapes after 15 stall cycles
      track_clear();
      put_word(1'b1, 1'b1, {$urandom, $urandom});
      drain(100);
      chk("t2_stall_start", first_rden - first_ne, 15);
      chk("t2_valid_cycles", v_cycles, 1);
      chk("t2_frame_cnt", frame_cnt, 16'(exp_frame));

      // Backpressure toggling every cycle
      track_clear();
      toggle_rdy = 1'b1;
      put_frame4();
      drain(100);
      toggle_rdy = 1'b0;
      out_ready  = 1'b1;
      chk("t3_outstanding", max_out <= 2, 1'b1);
      chk("t3_delivered", n_acc, 4);
      chk("t3_frame_cnt", frame_cnt, 16'(exp_frame));

      // Mid-frame sop truncates at w2, rest discarded through eop
      track_clear();
      for (int i = 0; i < 6; i++) put_word(i == 0 || i == 2, i == 5, {$urandom, $urandom});
      drain(100);
      chk("t4_delivered", n_acc, 3);
      chk("t4_drop_cnt", drop_cnt, 16'(exp_drop));
      chk("t4_frame_cnt", frame_cnt, 16'(exp_frame));

      // Oversize frame: 190th word carries the error eop
      track_clear();
      for (int i = 0; i < 200; i++) put_word(i == 0, i == 199, {$urandom, $urandom});
      drain(800);
      chk("t5_delivered", n_acc, 190);
      chk("t5_drop_cnt", drop_cnt, 16'(exp_drop));
      chk("t5_frame_cnt", frame_cnt, 16'(exp_frame));

      // Reset while w2 is held on the output
      track_clear();
      for (int i = 0; i < 4; i++) begin
         logic [63:0] pl;
         pl = {$urandom, $urandom};
         if (i == 2) pl2 = pl;
         put_word(i == 0, i == 3, pl);
      end
      n = 0;
      while (n_acc < 2 && n < 50) begin
         tick();
         n++;
      end
      chk("t6_two_accepted", n_acc, 2);
      out_ready = 1'b0;
      tick();
      tick();
      #2;
      chk("t6_w2_valid", out_valid, 1'b1);
      chk("t6_w2_data", out_data, pl2);
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_data", out_data, 64'h0);
      chk("t6_rst_flags", {out_sop, out_eop, out_err}, 3'b000);
      chk("t6_rst_frame_cnt", frame_cnt, 16'h0);
      chk("t6_rst_drop_cnt", drop_cnt, 16'h0);
      chk("t6_rst_rden", fifo_rden, 1'b0);
      fifo_q.delete();
      wr_q.delete();
      exp_q.delete();
      m_in = 1'b0; m_drop = 1'b0; m_cnt = 0;
      exp_frame = 0; exp_drop = 0;
      prev_stall   = 1'b0;
      fifo_rdempty = 1'b1;
      fifo_usedw   = '0;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (2) tick();

      // Normal frame after reset
      track_clear();
      put_frame4();
      drain(100);
      chk("t7_delivered", n_acc, 4);
      chk("t7_frame_cnt", frame_cnt, 16'(exp_frame));
      chk("t7_drop_cnt", drop_cnt, 16'(exp_drop));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
